// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bundle: redirect, instruction memory and decode-side handshake
interface fetch_unit_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int OW = $clog2(DEPTH) + 1;

    logic             jump;
    logic [WIDTH-1:0] jump_addr;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_inst;
    logic [WIDTH-1:0] out_pc;
    logic [OW-1:0]    occupancy;

    // fetch unit side
    modport master (
        input  jump, jump_addr, imem_data, out_ready,
        output imem_req, imem_addr, out_valid, out_inst, out_pc, occupancy
    );

    // environment side: execute stage, instruction memory and decode
    modport slave (
        output jump, jump_addr, imem_data, out_ready,
        input  imem_req, imem_addr, out_valid, out_inst, out_pc, occupancy
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction prefetch with FIFO queue and jump redirect; optional FETCH_BYPASS_EN
module fetch_unit #(
    parameter int               WIDTH      = 32,
    parameter int               DEPTH      = 4,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [WIDTH-1:0] STEP = WIDTH'(WIDTH / 8);

    logic [WIDTH-1:0] fpc;
    logic [WIDTH-1:0] pending_pc;
    logic             pending;
    logic [WIDTH-1:0] inst_q [DEPTH];
    logic [WIDTH-1:0] pc_q   [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [OW-1:0]    count;

    logic             jmp;
    logic             issue;
    logic             pop;
    logic             push;
    logic             deq;
    logic             bypass_head;
    logic [OW-1:0]    occ;
    logic [WIDTH-1:0] issue_addr;

    // issue/accept decisions; a jump overrides the occupancy throttle and kills the arriving response
    always_comb begin
        jmp         = bus.jump && !rst;
        issue_addr  = jmp ? {bus.jump_addr[WIDTH-1:2], 2'b00} : fpc;
        occ         = count + OW'(pending);
`ifdef FETCH_BYPASS_EN
        bypass_head = pending && !jmp && (count == '0);
`else
        bypass_head = 1'b0;
`endif
        bus.out_valid = !rst && ((count != '0) || bypass_head);
        pop           = bus.out_valid && bus.out_ready;
        issue         = !rst && (jmp || ((occ - OW'(pop)) < OW'(DEPTH)));
        push          = pending && !jmp && !(bypass_head && pop);
        deq           = pop && (count != '0);
        bus.imem_req  = issue;
        bus.imem_addr = issue_addr;
        bus.occupancy = rst ? '0 : occ;
        bus.out_inst  = bypass_head ? bus.imem_data : inst_q[rd_ptr];
        bus.out_pc    = bypass_head ? pending_pc    : pc_q[rd_ptr];
    end

    // fetch PC, in-flight tracking and queue pointers; a jump flushes the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc        <= RESET_ADDR;
            pending    <= 1'b0;
            pending_pc <= '0;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            pending <= issue;
            if (issue) begin
                pending_pc <= issue_addr;
                fpc        <= issue_addr + STEP;
            end
            if (jmp) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (deq)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + OW'(push) - OW'(deq);
            end
        end
    end

    // queue storage is not reset; contents are only visible while count is nonzero
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            inst_q[wr_ptr] <= bus.imem_data;
            pc_q[wr_ptr]   <= pending_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
    localparam logic [31:0] KEY = 32'hA5A5_0000;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    fetch_unit_if #(.WIDTH(32), .DEPTH(4)) bus();

    fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_ADDR(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // instruction memory: data is a fixed function of the address, one cycle later
    always @(posedge clk) begin
        if (bus.imem_req === 1'b1) bus.imem_data <= bus.imem_addr ^ KEY;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int i = 0;
        while (bus.out_valid !== 1'b1 && i < 8) begin
            adv();
            i++;
        end
        chk(tag, i, exp_lat);
    endtask

    task automatic deliver(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, bus.out_valid, 1'b1);
        chk({tag, "_pc"}, bus.out_pc, pc);
        chk({tag, "_inst"}, bus.out_inst, pc ^ KEY);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        adv();
        adv();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        bus.jump      = 1'b0;
        bus.jump_addr = 32'h0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        adv();
        adv();

        // reset state, with a jump that must be ignored
        bus.jump      = 1'b1;
        bus.jump_addr = 32'h200;
        #1;
        chk("rst_req", bus.imem_req, 1'b0);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_occ", bus.occupancy, 3'd0);
        adv();
        bus.jump = 1'b0;
        rst      = 1'b0;
        #1;
        chk("rel_req", bus.imem_req, 1'b1);
        chk("rel_addr", bus.imem_addr, 32'h0);
        chk("rel_valid", bus.out_valid, 1'b0);
        wait_valid("lat_reset", LAT);
        for (int k = 0; k < 6; k++) begin
            deliver("stream", 32'(4 * k));
            adv();
        end

        // stall until full, then resume without loss or duplication
        bus.out_ready = 1'b0;
        reset_dut();
        repeat (5) adv();
        chk("stall5_occ", bus.occupancy, 3'd4);
        chk("stall5_req", bus.imem_req, 1'b0);
        chk("stall5_pc", bus.out_pc, 32'h0);
        repeat (5) adv();
        chk("stall10_occ", bus.occupancy, 3'd4);
        chk("stall10_req", bus.imem_req, 1'b0);
        deliver("stall10", 32'h0);
        bus.out_ready = 1'b1;
        #1;
        chk("resume_req", bus.imem_req, 1'b1);
        chk("resume_addr", bus.imem_addr, 32'h10);
        for (int k = 0; k < 8; k++) begin
            deliver("resume", 32'(4 * k));
            adv();
        end

        // jump with two entries queued and one in flight
        bus.out_ready = 1'b0;
        reset_dut();
        adv();
        adv();
        adv();
        chk("prejump_occ", bus.occupancy, 3'd3);
        bus.jump      = 1'b1;
        bus.jump_addr = 32'h103;
        #1;
        chk("jump_req", bus.imem_req, 1'b1);
        chk("jump_addr", bus.imem_addr, 32'h100);
        adv();
        bus.jump      = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("postjump_occ", bus.occupancy, 3'd1);
        wait_valid("lat_jump", LAT - 1);
        deliver("jump_t0", 32'h100);
        adv();
        deliver("jump_t1", 32'h104);

        // back-to-back jumps: only the second target survives
        adv();
        bus.jump      = 1'b1;
        bus.jump_addr = 32'h40;
        #1;
        chk("bb_addr0", bus.imem_addr, 32'h40);
        adv();
        bus.jump_addr = 32'h80;
        #1;
        chk("bb_addr1", bus.imem_addr, 32'h80);
        adv();
        bus.jump = 1'b0;
        #1;
        wait_valid("lat_bb", LAT - 1);
        deliver("bb_t0", 32'h80);
        adv();
        deliver("bb_t1", 32'h84);

        // one-cycle reset while full
        bus.out_ready = 1'b0;
        repeat (6) adv();
        chk("full_occ", bus.occupancy, 3'd4);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_req", bus.imem_req, 1'b0);
        chk("mid_rst_occ", bus.occupancy, 3'd0);
        adv();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("after_rst_valid", bus.out_valid, 1'b0);
        chk("after_rst_req", bus.imem_req, 1'b1);
        chk("after_rst_addr", bus.imem_addr, 32'h0);
        wait_valid("lat_midrst", LAT);
        deliver("midrst_t0", 32'h0);

        // address wrap at the top of the address space, with an unaligned target
        adv();
        bus.jump      = 1'b1;
        bus.jump_addr = 32'hFFFF_FFFE;
        #1;
        chk("wrap_jaddr", bus.imem_addr, 32'hFFFF_FFFC);
        adv();
        bus.jump = 1'b0;
        #1;
        chk("wrap_req", bus.imem_req, 1'b1);
        chk("wrap_addr", bus.imem_addr, 32'h0);
        wait_valid("lat_wrap", LAT - 1);
        deliver("wrap_t0", 32'hFFFF_FFFC);
        chk("wrap_inst_const", bus.out_inst, 32'h5A5A_FFFC);
        adv();
        deliver("wrap_t1", 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
